// File: rtl/mult_div_unit_pkg.sv
// Shared HI/LO operation encoding and default latencies for the E-stage multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_unit_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // True for the four ops that occupy the unit for a multi-cycle busy period.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational mult/multu/div/divu datapath producing {hi,lo} plus a divide-by-zero hold flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is consumed by the owning unit only at issue.
module md_arith
   import mult_div_unit_pkg::*;
(
   input  logic [3:0]  i_md_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_res,
   output logic        o_hold
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_b_safe;
   logic [31:0] w_sq;
   logic [31:0] w_sr;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic        w_b_zero;
   logic        w_ovf;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Divisor forced to 1 on zero so the dividers never see a zero operand; the result is discarded anyway.
   assign w_b_zero = (i_b == 32'd0);
   assign w_b_safe = w_b_zero ? 32'd1 : i_b;
   // -2^31 / -1 overflows 32 bits; pin it to the wrapped quotient with zero remainder.
   assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

   // Signed divide truncates toward zero; the remainder follows the sign of the dividend.
   always_comb begin
      w_sq = 32'd0;
      w_sr = 32'd0;
      if (w_ovf) begin
         w_sq = 32'h8000_0000;
         w_sr = 32'd0;
      end else begin
         w_sq = $signed(i_a) / $signed(w_b_safe);
         w_sr = $signed(i_a) % $signed(w_b_safe);
      end
   end

   assign w_uq = i_a / w_b_safe;
   assign w_ur = i_a % w_b_safe;

   // Select the result for the requested op; non-arith ops yield zero.
   always_comb begin
      o_res  = 64'd0;
      o_hold = 1'b0;
      case (i_md_op)
         MD_MULT:  o_res = w_prod_s;
         MD_MULTU: o_res = w_prod_u;
         MD_DIV: begin
            o_res  = {w_sr, w_sq};
            o_hold = w_b_zero;
         end
         MD_DIVU: begin
            o_res  = {w_ur, w_uq};
            o_hold = w_b_zero;
         end
         default: o_res = 64'd0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; issues mult/div, handles mthi/mtlo and mfhi/mflo.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles after issue; HI/LO visible the cycle after.
// Backpressure: md_busy blocks new issue and mthi/mtlo; the hazard unit stalls D on md_start/md_busy.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        md_start,
   output logic        md_busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] md_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_hold;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_hi_tmp;
   logic [31:0]   r_lo_tmp;

   logic [63:0]   w_res;
   logic          w_hold;
   logic          w_done;

   md_arith u_arith (
      .i_md_op (md_op),
      .i_a     (A),
      .i_b     (B),
      .o_res   (w_res),
      .o_hold  (w_hold)
   );

   assign md_start = is_muldiv(md_op) && !req && !r_busy;
   // Last busy cycle: the counter was loaded with N and has counted down to 1.
   assign w_done   = r_busy && (r_cnt == CW'(1));

   // Issue latches the result and loads the countdown; the busy period ends when the count expires.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_hold   <= 1'b0;
         r_hi_tmp <= 32'd0;
         r_lo_tmp <= 32'd0;
      end else if (md_start) begin
         r_hi_tmp <= w_res[63:32];
         r_lo_tmp <= w_res[31:0];
         r_hold   <= w_hold;
         r_cnt    <= is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_cnt <= r_cnt - CW'(1);
         if (w_done) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Architectural HI/LO: commit a finished op (unless divide-by-zero) or take an unflushed mthi/mtlo.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_done) begin
         if (!r_hold) begin
            r_hi <= r_hi_tmp;
            r_lo <= r_lo_tmp;
         end
      end else if (!r_busy && !req) begin
         if (md_op == MD_MTHI) begin
            r_hi <= A;
         end
         if (md_op == MD_MTLO) begin
            r_lo <= A;
         end
      end
   end

   // mfhi/mflo read the committed registers only; pending results are not bypassed.
   always_comb begin
      md_out = 32'd0;
      if (md_op == MD_MFHI) begin
         md_out = r_hi;
      end else if (md_op == MD_MFLO) begin
         md_out = r_lo;
      end
   end

   assign md_busy = r_busy;
   assign HI      = r_hi;
   assign LO      = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus random ops against a timestamp model.
// Latency: model expects busy for 5 (mult) / 10 (div) cycles after issue.
// Backpressure: random ops are offered every cycle, including while busy.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int LAT_MULT = 5;
   localparam int LAT_DIV  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        md_start;
   logic        md_busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] md_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .md_start (md_start),
      .md_busy  (md_busy),
      .HI       (HI),
      .LO       (LO),
      .md_out   (md_out)
   );

   // Reference arithmetic in 64-bit integers straight from the instruction definitions.
   function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          q;
      longint          rm;
      longint unsigned uq;
      longint unsigned urm;
      logic [63:0]     r = 64'd0;
      case (op)
         MD_MULT:  r = sa * sb;
         MD_MULTU: r = ua * ub;
         MD_DIV: if (b != 32'd0) begin
            q  = sa / sb;
            rm = sa % sb;
            r  = {rm[31:0], q[31:0]};
         end
         MD_DIVU: if (b != 32'd0) begin
            uq  = ua / ub;
            urm = ua % ub;
            r   = {urm[31:0], uq[31:0]};
         end
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   // Model: an issued op is active until the cycle stamp reaches issue + latency.
   int unsigned tnow  = 0;
   int unsigned m_end = 0;
   logic        m_act = 1'b0;
   logic        m_hold = 1'b0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
   logic [63:0] m_r;

   always @(posedge clk) begin
      tnow <= tnow + 1;
      if (reset) begin
         m_hi  <= 32'd0;
         m_lo  <= 32'd0;
         m_act <= 1'b0;
      end else if (m_act) begin
         if (tnow == m_end) begin
            m_act <= 1'b0;
            if (!m_hold) begin
               m_hi <= m_phi;
               m_lo <= m_plo;
            end
         end
      end else if (!req) begin
         if (is_muldiv(md_op)) begin
            m_r    = ref_res(md_op, A, B);
            m_phi  <= m_r[63:32];
            m_plo  <= m_r[31:0];
            m_hold <= ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (B == 32'd0);
            m_act  <= 1'b1;
            m_end  <= tnow + (((md_op == MD_DIV) || (md_op == MD_DIVU)) ? LAT_DIV : LAT_MULT);
         end else if (md_op == MD_MTHI) begin
            m_hi <= A;
         end else if (md_op == MD_MTLO) begin
            m_lo <= A;
         end
      end
   end

   // Apply inputs just after a rising edge and return at the following falling edge.
   task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic rq, input logic rst);
      @(posedge clk);
      #1;
      md_op = op; A = a; B = b; req = rq; reset = rst;
      @(negedge clk);
   endtask

   // Idle the unit and count busy cycles, bounded so a stuck busy flag cannot hang the run.
   task automatic run_idle(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
         if (md_busy !== 1'b1) break;
         n++;
      end
   endtask

   task automatic test_reset;
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
      cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md_busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
      checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_mdout: got %h want 0", md_out); end
   endtask

   task automatic test_mult;
      cyc(MD_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0, 1'b0);
      checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL mult_start: got %b want 1", md_start); end
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_c0: got %b want 0", md_busy); end
      for (int k = 1; k <= 5; k++) begin
         if (k == 2) cyc(MD_MULT, 32'd7, 32'd9, 1'b0, 1'b0);
         else        cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
         checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mult_busy_c%0d: got %b want 1", k, md_busy); end
         if (k == 2) begin
            checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL mult_issue_while_busy: got %b want 0", md_start); end
         end
      end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mult_hi_early: got %h want 0", HI); end
      cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_c6: got %b want 0", md_busy); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mult_lo: got %h want fffffff4", LO); end
      checks++; if (md_out !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mult_mflo: got %h want fffffff4", md_out); end
      cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (md_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_mfhi: got %h want ffffffff", md_out); end
   endtask

   task automatic test_div;
      int n;
      cyc(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
      run_idle(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_len: got %0d want 10", n); end
      checks++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h want 3", LO); end
      checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 1", HI); end
      cyc(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      run_idle(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_len: got %0d want 10", n); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
   endtask

   task automatic test_div_zero;
      int n;
      cyc(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
      cyc(MD_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h want 12345678", HI); end
      checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo: got %h want 9abcdef0", LO); end
      cyc(MD_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
      run_idle(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div0_busy_len: got %0d want 10", n); end
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi: got %h want 12345678", HI); end
      checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL div0_lo: got %h want 9abcdef0", LO); end
   endtask

   task automatic test_flush;
      int n;
      cyc(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
      checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL flush_mult_start: got %b want 0", md_start); end
      cyc(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_mult_busy: got %b want 0", md_busy); end
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL flush_hi: got %h want 12345678", HI); end
      checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL flush_lo: got %h want 9abcdef0", LO); end
      cyc(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b0);
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL req_inflight_busy: got %b want 1", md_busy); end
      run_idle(n);
      checks++; if (n !== 2) begin errors++; $display("FAIL req_inflight_len: got %0d want 2", n); end
      checks++; if (HI !== 32'd1) begin errors++; $display("FAIL req_inflight_hi: got %h want 1", HI); end
      checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL req_inflight_lo: got %h want fffffffe", LO); end
   endtask

   task automatic test_reset_mid;
      logic bad = 1'b0;
      cyc(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_c4: got %b want 1", md_busy); end
      cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", md_busy); end
      checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo: got %h want 0", {HI, LO}); end
      for (int k = 0; k < 15; k++) begin
         cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
         if ((HI !== 32'd0) || (LO !== 32'd0) || (md_busy !== 1'b0)) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_late_update: got HI=%h LO=%h want 0", HI, LO); end
   endtask

   task automatic test_random;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        rq;
      logic        exp_start;
      logic [31:0] exp_out;
      for (int k = 0; k < 400; k++) begin
         op = 4'($urandom_range(0, 8));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         rq = ($urandom_range(0, 7) == 0);
         cyc(op, a, b, rq, 1'b0);
         exp_start = !m_act && is_muldiv(op) && !rq;
         exp_out   = (op == MD_MFHI) ? m_hi : ((op == MD_MFLO) ? m_lo : 32'd0);
         checks++; if (md_start !== exp_start) begin errors++; $display("FAIL rnd_start[%0d]: got %b want %b", k, md_start, exp_start); end
         checks++; if (md_busy !== m_act) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", k, md_busy, m_act); end
         checks++; if (HI !== m_hi) begin errors++; $display("FAIL rnd_hi[%0d]: got %h want %h", k, HI, m_hi); end
         checks++; if (LO !== m_lo) begin errors++; $display("FAIL rnd_lo[%0d]: got %h want %h", k, LO, m_lo); end
         checks++; if (md_out !== exp_out) begin errors++; $display("FAIL rnd_mdout[%0d]: got %h want %h", k, md_out, exp_out); end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
